cpu_controller: RTL and testbench
=================================

// Module: cpu_controller
// PURPOSE
//  8-phase instruction sequencer for the VeriRISC CPU. Each instruction takes 8 phases
//  (more if memory stalls). Drives the mux, memory, IR, PC and accumulator strobes
//  around the ALU, using the IR opcode and the ALU a_is_zero flag. HLT stops the
//  sequencer until reset.
// PARAMETERS
//  OPW       3   opcode width; encodings fixed below, must not be overridden
//  NPHASE    8   phases per instruction; fixed, documents phase counter range
// PORTS
//  clk       in   1    rising-edge clock
//  rst_n     in   1    asynchronous active-low reset
//  opcode    in   3    IR opcode: HLT0 SKZ1 ADD2 AND3 XOR4 LDA5 STO6 JMP7
//  zero      in   1    ALU a_is_zero (accumulator == 0)
//  mem_ready in   1    memory ready; tie 1 for single-cycle memory
//  sel       out  1    address mux: 1=PC, 0=IR operand
//  rd        out  1    memory read enable
//  ld_ir     out  1    load instruction register
//  inc_pc    out  1    increment PC
//  ld_pc     out  1    load PC from IR operand
//  ld_ac     out  1    load accumulator from ALU
//  data_e    out  1    drive accumulator onto data bus
//  wr        out  1    memory write strobe
//  halt      out  1    sticky halted indicator
//  phase     out  3    current phase, for debug/trace
//  instr_done out 1    1-cycle pulse in last phase of a completed instruction
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  - While rst_n=0: phase=0, halted=0, sel=1, all other outputs 0.
//  - Registered state: phase[2:0], halted. All strobes are combinational decode of
//    (phase, opcode, zero, halted). ALUOP = ADD|AND|XOR|LDA.
//  - Phases and strobes (anything not listed is 0):
//    0 INST_ADDR : sel
//    1 INST_FETCH: sel rd
//    2 INST_LOAD : sel rd ld_ir
//    3 IDLE      : sel rd ld_ir
//    4 OP_ADDR   : inc_pc=!HLT; HLT sets halted at this clock edge
//    5 OP_FETCH  : rd=ALUOP
//    6 ALU_OP    : rd=ALUOP; inc_pc=SKZ&zero; ld_pc=JMP; data_e=STO
//    7 STORE     : rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; data_e=STO; wr=STO; instr_done
//  - Advance: phase+1 each clock. 7 wraps to 0.
//  - Stall: phases 1 and 5 advance only when mem_ready=1. Stall applies in phase 5
//    only when the opcode reads memory (ALUOP). Otherwise mem_ready is ignored.
//    During a stall the strobes hold their values.
//  - Halt:
//    - In phase 4 with opcode=HLT, halt=1 combinationally that cycle.
//    - Next edge: halted=1 and phase freezes at 4.
//    - While halted: halt=1, all other strobes 0 (including sel, inc_pc, instr_done).
//      Only reset exits.
//  - SKZ with zero=0, and HLT: no memory access in phases 5-7.
//    SKZ with zero=1: exactly one extra inc_pc (phase 6).
//  - zero is sampled only in phase 6. Changes on zero elsewhere have no effect.
//  - Reset mid-instruction: asynchronous jump to the reset values above. The first
//    clock after release is phase 0; no partial strobe survives reset.
//  - Total latency with no stalls: 8 cycles per instruction. Each stall cycle adds 1.
// TESTING
//  - Reset, mem_ready=1, opcode=ADD: phases 0..7 repeat. rd high in 1,2,3,5,6,7.
//    ld_ir in 2,3. inc_pc in 4. ld_ac and instr_done in 7. No wr/ld_pc.
//  - opcode=STO: data_e in phases 6,7. wr only in 7. rd=0 in 5-7.
//  - opcode=SKZ: zero=1 gives inc_pc in phases 4 and 6; zero=0 gives inc_pc only
//    in phase 4.
//  - opcode=JMP: ld_pc in phases 6 and 7, inc_pc in 4.
//  - opcode=HLT: halt=1 in phase 4 with inc_pc=0. Phase stays 4 and halt stays 1 for
//    20 cycles. rst_n pulse gives phase=0, halt=0.
//  - mem_ready=0 for 3 cycles in phase 1, then in phase 5 (LDA): phase held, rd held
//    at 1. Instruction completes in 14 cycles. Assert rst_n=0 mid-phase 6: outputs
//    reset immediately, with no clock needed.

Source files
------------

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer for the VeriRISC CPU: walks fetch/decode/execute
// phases, stalls on slow memory, and decodes the bus/register strobes around the ALU.
module cpu_controller #(
    parameter int OPW    = 3,
    parameter int NPHASE = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           sel,
    output logic           rd,
    output logic           ld_ir,
    output logic           inc_pc,
    output logic           ld_pc,
    output logic           ld_ac,
    output logic           data_e,
    output logic           wr,
    output logic           halt,
    output logic [2:0]     phase,
    output logic           instr_done
);

    localparam int PW = $clog2(NPHASE);

    typedef enum logic [PW-1:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [OPW-1:0] OP_HLT = 3'd0;
    localparam logic [OPW-1:0] OP_SKZ = 3'd1;
    localparam logic [OPW-1:0] OP_ADD = 3'd2;
    localparam logic [OPW-1:0] OP_AND = 3'd3;
    localparam logic [OPW-1:0] OP_XOR = 3'd4;
    localparam logic [OPW-1:0] OP_LDA = 3'd5;
    localparam logic [OPW-1:0] OP_STO = 3'd6;
    localparam logic [OPW-1:0] OP_JMP = 3'd7;

    phase_t state;
    logic   halted;
    logic   is_aluop;
    logic   is_hlt_now;
    logic   stall;

    assign is_aluop   = (opcode == OP_ADD) || (opcode == OP_AND) ||
                        (opcode == OP_XOR) || (opcode == OP_LDA);
    assign is_hlt_now = (state == OP_ADDR) && (opcode == OP_HLT);
    // Only the instruction fetch and operand reads wait on memory.
    assign stall      = ((state == INST_FETCH) && !mem_ready) ||
                        ((state == OP_FETCH) && is_aluop && !mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= INST_ADDR;
            halted <= 1'b0;
        end else if (!halted) begin
            if (is_hlt_now)
                halted <= 1'b1;
            else if (!stall)
                state <= phase_t'(state + 3'd1);
        end
    end

    assign phase = state;

    always_comb begin
        sel        = 1'b0;
        rd         = 1'b0;
        ld_ir      = 1'b0;
        inc_pc     = 1'b0;
        ld_pc      = 1'b0;
        ld_ac      = 1'b0;
        data_e     = 1'b0;
        wr         = 1'b0;
        instr_done = 1'b0;
        halt       = halted || is_hlt_now;
        // A halted sequencer drives nothing but the halt flag.
        if (!halted) begin
            case (state)
                INST_ADDR: sel = 1'b1;
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: inc_pc = (opcode != OP_HLT);
                OP_FETCH: rd = is_aluop;
                ALU_OP: begin
                    rd     = is_aluop;
                    inc_pc = (opcode == OP_SKZ) && zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                STORE: begin
                    rd         = is_aluop;
                    ld_ac      = is_aluop;
                    ld_pc      = (opcode == OP_JMP);
                    data_e     = (opcode == OP_STO);
                    wr         = (opcode == OP_STO);
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: per-phase strobe tables for each opcode class,
// memory stalls, halt stickiness and asynchronous reset.
module tb_cpu_controller;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    logic       clk;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt, instr_done;
    logic [2:0] phase;

    int errors = 0;
    int checks = 0;

    // Strobe order: sel rd ld_ir inc_pc ld_pc ld_ac data_e wr halt instr_done
    logic [9:0]  exp_tab [8];
    logic [12:0] obs;

    assign obs = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt, instr_done, phase};

    cpu_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .sel        (sel),
        .rd         (rd),
        .ld_ir      (ld_ir),
        .inc_pc     (inc_pc),
        .ld_pc      (ld_pc),
        .ld_ac      (ld_ac),
        .data_e     (data_e),
        .wr         (wr),
        .halt       (halt),
        .phase      (phase),
        .instr_done (instr_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Starts in phase 0, checks all eight phases, leaves the DUT back in phase 0.
    // zero takes z6 only in phase 6 and its inverse elsewhere; mem_ready takes mr5 in phase 5.
    task automatic run_instr(input string tag, input logic z6, input logic mr5);
        check($sformatf("%s_p0", tag), {exp_tab[0], 3'd0});
        for (int p = 1; p < 8; p++) begin
            @(posedge clk);
            zero      = (p == 6) ? z6 : ~z6;
            mem_ready = (p == 5) ? mr5 : 1'b1;
            #2;
            check($sformatf("%s_p%0d", tag, p), {exp_tab[p], p[2:0]});
        end
        @(posedge clk);
        zero      = 1'b0;
        mem_ready = 1'b1;
        #2;
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = OP_ADD;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #12;
        check("reset_hold", {10'b1000000000, 3'd0});
        rst_n = 1'b1;
        #1;

        exp_tab = '{10'b1000000000, 10'b1100000000, 10'b1110000000, 10'b1110000000,
                    10'b0001000000, 10'b0100000000, 10'b0100000000, 10'b0100010001};
        run_instr("add_a", 1'b0, 1'b1);
        run_instr("add_b", 1'b1, 1'b1);

        opcode  = OP_STO;
        exp_tab = '{10'b1000000000, 10'b1100000000, 10'b1110000000, 10'b1110000000,
                    10'b0001000000, 10'b0000000000, 10'b0000001000, 10'b0000001101};
        run_instr("sto", 1'b0, 1'b0);

        opcode  = OP_SKZ;
        exp_tab = '{10'b1000000000, 10'b1100000000, 10'b1110000000, 10'b1110000000,
                    10'b0001000000, 10'b0000000000, 10'b0001000000, 10'b0000000001};
        run_instr("skz_z1", 1'b1, 1'b0);
        exp_tab[6] = 10'b0000000000;
        run_instr("skz_z0", 1'b0, 1'b0);

        opcode  = OP_JMP;
        exp_tab = '{10'b1000000000, 10'b1100000000, 10'b1110000000, 10'b1110000000,
                    10'b0001000000, 10'b0000000000, 10'b0000100000, 10'b0000100001};
        run_instr("jmp", 1'b0, 1'b0);

        // LDA with three stall cycles in phase 1 and three in phase 5: 14 cycles total.
        opcode  = OP_LDA;
        exp_tab = '{10'b1000000000, 10'b1100000000, 10'b1110000000, 10'b1110000000,
                    10'b0001000000, 10'b0100000000, 10'b0100000000, 10'b0100010001};
        mem_ready = 1'b0;
        check("lda_p0", {exp_tab[0], 3'd0});
        @(posedge clk); #2;
        check("lda_p1", {exp_tab[1], 3'd1});
        repeat (3) begin
            @(posedge clk); #2;
            check("lda_stall_p1", {exp_tab[1], 3'd1});
        end
        mem_ready = 1'b1;
        for (int p = 2; p < 6; p++) begin
            @(posedge clk); #2;
            check($sformatf("lda_p%0d", p), {exp_tab[p], p[2:0]});
        end
        mem_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #2;
            check("lda_stall_p5", {exp_tab[5], 3'd5});
        end
        mem_ready = 1'b1;
        for (int p = 6; p < 8; p++) begin
            @(posedge clk); #2;
            check($sformatf("lda_p%0d", p), {exp_tab[p], p[2:0]});
        end
        @(posedge clk); #2;
        check("lda_wrap", {exp_tab[0], 3'd0});

        // Second LDA, reset asserted mid-phase 6 with no clock edge.
        for (int p = 1; p < 7; p++) begin
            @(posedge clk); #2;
        end
        check("lda2_p6", {exp_tab[6], 3'd6});
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", {10'b1000000000, 3'd0});
        #1;
        rst_n = 1'b1;
        #1;
        check("reset_release", {10'b1000000000, 3'd0});
        @(posedge clk); #2;
        check("after_reset_p1", {10'b1100000000, 3'd1});
        for (int p = 2; p < 9; p++) begin
            @(posedge clk); #2;
        end
        check("after_reset_p0", {10'b1000000000, 3'd0});

        // HLT: halt in phase 4 with no inc_pc, then frozen until reset.
        opcode = OP_HLT;
        for (int p = 1; p < 4; p++) begin
            @(posedge clk); #2;
            check($sformatf("hlt_p%0d", p), {exp_tab[p], p[2:0]});
        end
        @(posedge clk); #2;
        check("hlt_p4", {10'b0000000010, 3'd4});
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            zero      = 1'($urandom_range(0, 1));
            if (i >= 10) opcode = OP_ADD;
            #2;
            check($sformatf("halted_%0d", i), {10'b0000000010, 3'd4});
        end
        rst_n = 1'b0;
        #1;
        check("halt_reset", {10'b1000000000, 3'd0});
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        zero      = 1'b0;
        #1;
        exp_tab = '{10'b1000000000, 10'b1100000000, 10'b1110000000, 10'b1110000000,
                    10'b0001000000, 10'b0100000000, 10'b0100000000, 10'b0100010001};
        run_instr("post_halt_add", 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
